// File: rtl/dtpu_infifo_unpacker.sv
// dtpu_infifo_unpacker: streams 64-bit FIFO words into a 128-bit bit queue and emits K-lane mixed-precision vectors
// clk, reset (sync, active-high); enable freezes all state; flush clears the queue and latches data_type/sign_ext;
// infifo_dout/infifo_empty/infifo_read: FWFT FIFO side, read is combinational; vec_data/vec_valid/vec_ready: MXU side;
// fill_bits: buffered bit count 0..128; vec_count: saturating count of delivered vectors since reset/flush
module dtpu_infifo_unpacker #(
  parameter int K = 4,
  parameter int MAX_DW = 16,
  parameter int FIFO_DW = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [1:0]            data_type,
  input  logic                  sign_ext,
  input  logic [FIFO_DW-1:0]    infifo_dout,
  input  logic                  infifo_empty,
  output logic                  infifo_read,
  output logic [K*MAX_DW-1:0]   vec_data,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [7:0]            fill_bits,
  output logic [31:0]           vec_count
);
  localparam int BW = 2 * FIFO_DW;
  logic [BW-1:0] buf_q, shifted;
  logic [7:0] fill_q, ew, need, base;
  logic [31:0] cnt_q;
  logic [1:0] cfg_type;
  logic cfg_sext, pop;
  assign ew = 8'(MAX_DW >> cfg_type);
  assign need = 8'(K) * ew;
  // reset gates the pop so no upstream word is lost while state is being cleared
  assign infifo_read = !reset & enable & !flush & !infifo_empty & (fill_q <= 8'(FIFO_DW));
  assign vec_valid = fill_q >= need;
  assign pop = vec_valid & vec_ready & enable & !flush;
  assign shifted = pop ? buf_q >> need : buf_q;
  // bits at and above fill are always zero, so the new word can simply be OR-ed in
  assign base = pop ? fill_q - need : fill_q;
  assign fill_bits = fill_q;
  assign vec_count = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      cfg_type <= '0;
      cfg_sext <= 1'b0;
    end else if (enable & flush) begin
      buf_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      cfg_type <= data_type;
      cfg_sext <= sign_ext;
    end else if (enable) begin
      buf_q <= shifted | (infifo_read ? BW'(infifo_dout) << base : '0);
      fill_q <= base + (infifo_read ? 8'(FIFO_DW) : 8'd0);
      if (pop && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (fill_q <= 8'(BW));
  end
  for (genvar i = 0; i < K; i++) begin : g_lane
    logic [MAX_DW-1:0] raw, mask;
    logic sgn;
    assign raw = MAX_DW'(buf_q >> (8'(i) * ew));
    assign mask = {MAX_DW{1'b1}} >> (8'(MAX_DW) - ew);
    // top bit of the element field: inside mask but outside mask>>1
    assign sgn = cfg_sext & |(raw & mask & ~(mask >> 1));
    assign vec_data[i*MAX_DW +: MAX_DW] = (raw & mask) | (sgn ? ~mask : '0);
  end
endmodule
